// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-line rising-edge capture with round-robin single-port event delivery
module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 8,
    parameter int ID_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     data_in,
    input  logic [N-1:0]     mask,
    input  logic             evt_ready,
    input  logic             clr_overflow,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic [N-1:0]     overflow,
    output logic [CNT_W-1:0] evt_count
);

    logic [N-1:0]    prev;
    logic [N-1:0]    pend;
    logic [ID_W-1:0] last;

    logic [N-1:0]    rise;
    logic            slot_free;
    logic            any_pend;
    logic            load;
    logic            handshake;
    logic [ID_W-1:0] winner;
    logic [N-1:0]    load_vec;
    logic [N-1:0]    ovf_set;

    // Qualified rising edges and slot/handshake status
    always_comb begin
        rise      = data_in & ~prev & ~mask;
        slot_free = ~evt_valid | evt_ready;
        handshake = evt_valid & evt_ready;
        any_pend  = |pend;
        load      = slot_free & any_pend;
    end

    // Round-robin search starting one past the last granted line, wrapping mod N
    always_comb begin
        logic            found;
        logic [ID_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ID_W'((int'(last) + k) % N);
            if (!found && pend[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // One-hot of the line being moved into the slot, and edges lost on busy lines
    always_comb begin
        load_vec = '0;
        if (load) begin
            load_vec[winner] = 1'b1;
        end
        ovf_set = rise & pend & ~load_vec;
    end

    // Edge history: a line high at reset release is seen as a fresh edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= data_in;
        end
    end

    // Pending bits: a new edge wins over a same-cycle load clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~load_vec) | rise;
        end
    end

    // Sticky overflow; a new loss beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= '0;
        end else if (clr_overflow) begin
            overflow <= ovf_set;
        end else begin
            overflow <= overflow | ovf_set;
        end
    end

    // Output slot and round-robin pointer; held stable under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            last      <= ID_W'(N - 1);
        end else if (slot_free) begin
            if (any_pend) begin
                evt_valid <= 1'b1;
                evt_id    <= winner;
                last      <= winner;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

    // Delivered-event counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_count <= '0;
        end else if (handshake) begin
            evt_count <= evt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int ID_W  = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     data_in;
    logic [N-1:0]     mask;
    logic             evt_ready;
    logic             clr_overflow;
    logic             evt_valid;
    logic [ID_W-1:0]  evt_id;
    logic [N-1:0]     overflow;
    logic [CNT_W-1:0] evt_count;

    int tests_run;
    int tests_failed;

    edge_event_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .mask         (mask),
        .evt_ready    (evt_ready),
        .clr_overflow (clr_overflow),
        .evt_valid    (evt_valid),
        .evt_id       (evt_id),
        .overflow     (overflow),
        .evt_count    (evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        data_in = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        data_in      = '0;
        mask         = '0;
        evt_ready    = 1'b1;
        clr_overflow = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id",    32'(evt_id),    32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_cnt",   32'(evt_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-edge latency on line 2
        data_in = 4'b0100;
        tick();
        check("lat_not_yet", 32'(evt_valid), 32'd0);
        tick();
        check("lat_valid", 32'(evt_valid), 32'd1);
        check("lat_id",    32'(evt_id),    32'd2);
        tick();
        check("lat_drop",  32'(evt_valid), 32'd0);
        check("lat_cnt",   32'(evt_count), 32'd1);
        tick();
        check("lat_quiet", 32'(evt_valid), 32'd0);

        // Simultaneous edges on 0,1,3 from a fresh reset
        do_reset();
        data_in = 4'b1011;
        tick();
        tick();
        check("sim_v0",  32'(evt_valid), 32'd1);
        check("sim_id0", 32'(evt_id),    32'd0);
        tick();
        check("sim_id1", 32'(evt_id),    32'd1);
        tick();
        check("sim_id3", 32'(evt_id),    32'd3);
        tick();
        check("sim_end", 32'(evt_valid), 32'd0);
        check("sim_cnt", 32'(evt_count), 32'd3);
        data_in = 4'b0000;
        tick();
        data_in = 4'b1001;
        tick();
        tick();
        check("wrap_id0", 32'(evt_id), 32'd0);
        tick();
        check("wrap_id3", 32'(evt_id), 32'd3);
        tick();
        check("wrap_end", 32'(evt_valid), 32'd0);
        check("wrap_cnt", 32'(evt_count), 32'd5);

        // Backpressure and overflow on line 1
        data_in   = 4'b0000;
        evt_ready = 1'b0;
        tick();
        data_in = 4'b0010;
        tick();
        tick();
        check("bp_valid", 32'(evt_valid), 32'd1);
        check("bp_id",    32'(evt_id),    32'd1);
        data_in = 4'b0000;
        tick();
        tick();
        tick();
        check("bp_hold", 32'(evt_id), 32'd1);
        data_in = 4'b0010;
        tick();
        check("bp_2nd_ovf", 32'(overflow), 32'd0);
        check("bp_2nd_v",   32'(evt_valid), 32'd1);
        data_in = 4'b0000;
        tick();
        data_in = 4'b0010;
        tick();
        check("bp_3rd_ovf", 32'(overflow), 32'b0010);
        data_in      = 4'b0000;
        clr_overflow = 1'b1;
        tick();
        check("ovf_clr", 32'(overflow), 32'd0);
        clr_overflow = 1'b0;
        data_in      = 4'b0000;
        tick();
        data_in      = 4'b0010;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'b0010);
        check("bp_cnt_hold",  32'(evt_count), 32'd5);
        data_in   = 4'b0000;
        evt_ready = 1'b1;
        tick();
        check("drain_v",   32'(evt_valid), 32'd1);
        check("drain_id",  32'(evt_id),    32'd1);
        check("drain_cnt", 32'(evt_count), 32'd6);
        tick();
        check("drain_end",  32'(evt_valid), 32'd0);
        check("drain_cnt2", 32'(evt_count), 32'd7);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;

        // Mask gates capture
        mask    = 4'b0100;
        data_in = 4'b0100;
        tick();
        tick();
        check("mask_v",   32'(evt_valid), 32'd0);
        check("mask_ovf", 32'(overflow),  32'd0);
        mask = 4'b0000;
        tick();
        tick();
        check("unmask_v", 32'(evt_valid), 32'd0);
        data_in = 4'b0000;
        tick();

        // Reset mid-operation
        evt_ready = 1'b0;
        data_in   = 4'b0111;
        tick();
        tick();
        check("mid_v", 32'(evt_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_v",   32'(evt_valid), 32'd0);
        check("mid_rst_id",  32'(evt_id),    32'd0);
        check("mid_rst_ovf", 32'(overflow),  32'd0);
        check("mid_rst_cnt", 32'(evt_count), 32'd0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        tick();
        check("rel_v0", 32'(evt_valid), 32'd0);
        tick();
        check("rel_id0", 32'(evt_id), 32'd0);
        tick();
        check("rel_id1", 32'(evt_id), 32'd1);
        tick();
        check("rel_id2", 32'(evt_id), 32'd2);
        tick();
        check("rel_end", 32'(evt_valid), 32'd0);
        check("rel_cnt", 32'(evt_count), 32'd3);

        // Counter wrap: 17 events on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            data_in = 4'(1 << (i % 4));
            tick();
            data_in = 4'b0000;
            tick();
        end
        tick();
        tick();
        tick();
        check("cnt_wrap",     32'(evt_count), 32'd1);
        check("cnt_wrap_ovf", 32'(overflow),  32'd0);
        check("cnt_wrap_v",   32'(evt_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
